// File: rtl/eth_rx_cmd.sv
// Drains the Ethernet receive packet RAM and replays its config-write records
// onto a valid/ready configuration bus, then releases the receiver.
module eth_rx_cmd #(
    parameter logic [7:0] MAGIC       = 8'hA5,
    parameter logic [7:0] MAX_RECORDS = 8'd15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        eth_rx_ready,
    output logic        eth_rx_read,
    output logic [5:0]  ram_addr,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  cfg_addr,
    output logic [23:0] cfg_data,
    output logic        cfg_valid,
    input  logic        cfg_ready,
    output logic        busy,
    output logic [15:0] good_pkt_count,
    output logic [15:0] bad_pkt_count
);

    // state     | meaning
    // IDLE      | waiting for eth_rx_ready
    // HDR_MAGIC | fetching byte 0, must equal MAGIC
    // HDR_COUNT | fetching record count N
    // REC_ADDR  | fetching record address byte
    // REC_D2..0 | fetching record data bytes, MSB first
    // ISSUE     | cfg write pending until cfg_ready
    // ACCEPT    | bump good counter
    // REJECT    | bump bad counter
    // RELEASE   | one-cycle eth_rx_read pulse
    // DRAIN     | wait for eth_rx_ready low
    typedef enum logic [3:0] {
        IDLE, HDR_MAGIC, HDR_COUNT, REC_ADDR, REC_D2, REC_D1, REC_D0,
        ISSUE, ACCEPT, REJECT, RELEASE, DRAIN
    } state_t;

    state_t      state, state_d;
    logic        phase, phase_d;
    logic [5:0]  ram_addr_d;
    logic [7:0]  n_q, n_d;
    logic [7:0]  rec_idx, rec_idx_d;
    logic [7:0]  cfg_addr_d;
    logic [23:0] cfg_data_d;
    logic        cfg_valid_d;
    logic [15:0] good_d, bad_d;

    assign eth_rx_read = (state == RELEASE);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            phase          <= 1'b0;
            ram_addr       <= '0;
            n_q            <= '0;
            rec_idx        <= '0;
            cfg_addr       <= '0;
            cfg_data       <= '0;
            cfg_valid      <= 1'b0;
            good_pkt_count <= '0;
            bad_pkt_count  <= '0;
        end else begin
            state          <= state_d;
            phase          <= phase_d;
            ram_addr       <= ram_addr_d;
            n_q            <= n_d;
            rec_idx        <= rec_idx_d;
            cfg_addr       <= cfg_addr_d;
            cfg_data       <= cfg_data_d;
            cfg_valid      <= cfg_valid_d;
            good_pkt_count <= good_d;
            bad_pkt_count  <= bad_d;
        end
    end

    // Fetch states spend one cycle waiting for RAM data (phase=0) and
    // capture on the second edge (phase=1).
    always_comb begin
        state_d     = state;
        phase_d     = phase;
        ram_addr_d  = ram_addr;
        n_d         = n_q;
        rec_idx_d   = rec_idx;
        cfg_addr_d  = cfg_addr;
        cfg_data_d  = cfg_data;
        cfg_valid_d = cfg_valid;
        good_d      = good_pkt_count;
        bad_d       = bad_pkt_count;

        unique case (state)
            IDLE: begin
                phase_d = 1'b0;
                if (eth_rx_ready) begin
                    ram_addr_d = 6'd0;
                    state_d    = HDR_MAGIC;
                end
            end
            HDR_MAGIC: begin
                phase_d = ~phase;
                if (phase) begin
                    if (ram_rdata != MAGIC) begin
                        state_d = REJECT;
                    end else begin
                        ram_addr_d = 6'd1;
                        state_d    = HDR_COUNT;
                    end
                end
            end
            HDR_COUNT: begin
                phase_d = ~phase;
                if (phase) begin
                    if (ram_rdata > MAX_RECORDS) begin
                        state_d = REJECT;
                    end else if (ram_rdata == 8'd0) begin
                        state_d = ACCEPT;
                    end else begin
                        n_d        = ram_rdata;
                        rec_idx_d  = 8'd0;
                        ram_addr_d = 6'd2;
                        state_d    = REC_ADDR;
                    end
                end
            end
            REC_ADDR: begin
                phase_d = ~phase;
                if (phase) begin
                    cfg_addr_d = ram_rdata;
                    ram_addr_d = ram_addr + 6'd1;
                    state_d    = REC_D2;
                end
            end
            REC_D2: begin
                phase_d = ~phase;
                if (phase) begin
                    cfg_data_d[23:16] = ram_rdata;
                    ram_addr_d        = ram_addr + 6'd1;
                    state_d           = REC_D1;
                end
            end
            REC_D1: begin
                phase_d = ~phase;
                if (phase) begin
                    cfg_data_d[15:8] = ram_rdata;
                    ram_addr_d       = ram_addr + 6'd1;
                    state_d          = REC_D0;
                end
            end
            REC_D0: begin
                phase_d = ~phase;
                // address is left on the last byte so it never passes 61
                if (phase) begin
                    cfg_data_d[7:0] = ram_rdata;
                    cfg_valid_d     = 1'b1;
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                if (cfg_ready) begin
                    cfg_valid_d = 1'b0;
                    if (rec_idx == n_q - 8'd1) begin
                        state_d = ACCEPT;
                    end else begin
                        rec_idx_d  = rec_idx + 8'd1;
                        ram_addr_d = ram_addr + 6'd1;
                        state_d    = REC_ADDR;
                    end
                end
            end
            ACCEPT: begin
                if (good_pkt_count != 16'hFFFF) good_d = good_pkt_count + 16'd1;
                state_d = RELEASE;
            end
            REJECT: begin
                if (bad_pkt_count != 16'hFFFF) bad_d = bad_pkt_count + 16'd1;
                state_d = RELEASE;
            end
            RELEASE: state_d = DRAIN;
            DRAIN: begin
                if (!eth_rx_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/eth_rx_cmd.md
Name: eth_rx_cmd

Overview:
Command sequencer that drains the 64-byte Ethernet receive packet RAM once the receiver flags a packet ready. It parses the payload as a list of configuration-register write records and replays them one at a time onto a valid/ready configuration bus. It then acknowledges the receiver with a one-cycle read pulse so the next packet can be captured. It sits between the receive RAM (read port) and the configuration register file.

Parameters:
MAGIC, 8'hA5, required value of payload byte 0
MAX_RECORDS, 15, maximum record count accepted (2 + 4*15 = 62 bytes fits in 64)

Ports:
clk  input  1  system clock; single clock domain
reset_n  input  1  asynchronous, active-low reset
eth_rx_ready  input  1  receiver has a complete 64-byte payload in RAM; held until read pulse
eth_rx_read  output  1  one-cycle release pulse to the receiver
ram_addr  output  6  packet RAM read address, registered
ram_rdata  input  8  packet RAM read data; valid the cycle after ram_addr is presented
cfg_addr  output  8  config register address
cfg_data  output  24  config write data
cfg_valid  output  1  config write pending
cfg_ready  input  1  config sink accepts the write
busy  output  1  high in any state other than IDLE
good_pkt_count  output  16  packets parsed OK, saturating
bad_pkt_count  output  16  packets rejected, saturating

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0, state IDLE.
  - If reset occurs mid-packet, no release pulse is issued. Because eth_rx_ready stays high, the same packet is reprocessed from byte 0 after reset. This is accepted behaviour.
- Payload format:
  - byte0 = MAGIC, byte1 = N (record count).
  - Records follow from byte 2, 4 bytes each: addr, data[23:16], data[15:8], data[7:0].
  - Bytes beyond 2+4N are ignored.
- Byte fetch rule:
  - Each byte costs exactly 2 cycles: ram_addr updates at edge t, the byte is captured at edge t+2.
  - The next ram_addr is issued at the same edge as the capture.
- States:
  - IDLE: on eth_rx_ready=1, set ram_addr=0 and go to HDR_MAGIC.
  - HDR_MAGIC: capture byte0. Mismatch → REJECT; else ram_addr=1, go to HDR_COUNT.
  - HDR_COUNT: capture N.
    - N > MAX_RECORDS → REJECT.
    - N = 0 → ACCEPT.
    - Otherwise rec_idx=0, ram_addr=2, go to REC_ADDR.
  - REC_ADDR, REC_D2, REC_D1, REC_D0: capture the four record bytes into the cfg_addr/cfg_data holding registers.
    - At the REC_D0 capture edge, cfg_valid<=1 and go to ISSUE.
  - ISSUE: hold cfg_valid, cfg_addr and cfg_data stable until an edge where cfg_ready=1; that edge completes the transfer and cfg_valid<=0.
    - Then if rec_idx = N-1 → ACCEPT; else rec_idx+1, ram_addr = next record base, go to REC_ADDR.
    - cfg_ready already high when valid rises completes the transfer at the next edge.
  - ACCEPT: good_pkt_count+1 (saturate at 16'hFFFF), go to RELEASE.
  - REJECT: bad_pkt_count+1 (saturate at 16'hFFFF), no cfg writes, go to RELEASE.
  - RELEASE: eth_rx_read=1 for exactly one cycle, go to DRAIN.
  - DRAIN: wait until eth_rx_ready=0 (the receiver drops it one cycle after the read pulse), then IDLE. A fresh packet is never parsed before ready has been seen low.
- Timing:
  - First cfg_valid rises exactly 12 cycles after the edge sampling eth_rx_ready=1.
  - Each subsequent record's cfg_valid rises 8 cycles after the previous handshake edge.
- Records are written strictly in payload order. Writes never overlap or repeat.
- ram_addr never exceeds 61.
- eth_rx_ready deasserting unexpectedly mid-parse is ignored; the sequence completes.

Test Plan:
- Payload A5 01 10 12 34 56, cfg_ready=1 → one write cfg_addr=8'h10, cfg_data=24'h123456; cfg_valid high 12 cycles after ready; one eth_rx_read pulse; good_pkt_count=1.
- Payload A5 03 + three records, cfg_ready stalled 5 cycles on record 2 → three writes in order; record 2 addr/data stable throughout the stall; no duplicates; single release pulse.
- Byte0=5A → zero cfg_valid; bad_pkt_count=1; eth_rx_read pulses; returns to IDLE after ready drops.
- N=16 → rejected, bad_pkt_count=1. N=15 → 15 writes, last record read from bytes 58-61. N=0 → no writes, good_pkt_count=1.
- reset_n low during ISSUE of record 1 (ready still high) → outputs 0 immediately; after release the packet is reparsed from byte 0 and all writes are reissued.
- good_pkt_count preloaded near 16'hFFFF via 65535 packets (or a forced value) → the next good packet holds at 16'hFFFF.
